// File: rtl/bp_types_pkg.sv
// Shared types and helpers for the fetch-stage branch target buffer.
// Default-width entry layout plus index/tag extraction and counter seed values.
package bp_types_pkg;

  localparam int BP_WORD_W  = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_CNT_W   = 2;
  localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W   = BP_WORD_W - BP_IDX_W - 2;

  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_W-1:0]   tag;
    logic [BP_WORD_W-3:0]  target;
    logic [BP_CNT_W-1:0]   cnt;
  } bp_entry_t;

  // Weakly-taken: MSB set, rest clear.
  function automatic logic [31:0] cnt_weak_taken(input int cnt_w);
    return 32'd1 << (cnt_w - 1);
  endfunction

  // Weakly-not-taken: MSB clear, rest set (0 for a 1-bit counter).
  function automatic logic [31:0] cnt_weak_ntaken(input int cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  function automatic logic [63:0] idx_of(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Next-value logic for an up/down counter that saturates at 0 and all-ones.
// Combinational; inc and dec together (or neither) hold the value.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc && !dec && (cur != '1))
      nxt = cur + W'(1);
    else if (dec && !inc && (cur != '0))
      nxt = cur - W'(1);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry direction counters: zero-latency lookup,
// single-cycle training from EX, saturating update/mispredict statistics.
module branch_predictor
  import bp_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16,
  parameter int WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  input  logic              upd_en,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              clear,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_ntaken(CNT_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-3:0] target;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  entry_t            bt_q [ENTRIES];
  entry_t            l_ent;
  entry_t            u_ent;
  logic [IDX_W-1:0]  l_idx;
  logic [IDX_W-1:0]  u_idx;
  logic [TAG_W-1:0]  l_tag;
  logic [TAG_W-1:0]  u_tag;
  logic              u_hit;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [STAT_W-1:0] upd_nxt;
  logic [STAT_W-1:0] mis_nxt;
  logic              unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^upd_target[1:0];

  assign l_idx = IDX_W'(idx_of(64'(lookup_pc), IDX_W));
  assign l_tag = TAG_W'(tag_of(64'(lookup_pc), IDX_W));
  assign u_idx = IDX_W'(idx_of(64'(upd_pc), IDX_W));
  assign u_tag = TAG_W'(tag_of(64'(upd_pc), IDX_W));

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign l_ent       = bt_q[l_idx];
  assign pred_hit    = l_ent.valid && (l_ent.tag == l_tag);
  assign pred_taken  = pred_hit && l_ent.cnt[CNT_W-1];
  assign pred_target = pred_taken ? {l_ent.target, 2'b00} : lookup_pc + WORD_W'(4);

  assign u_ent = bt_q[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  sat_counter #(.W(CNT_W)) u_dir_cnt (
    .cur (u_ent.cnt),
    .inc (upd_taken),
    .dec (!upd_taken),
    .nxt (cnt_nxt)
  );

  sat_counter #(.W(STAT_W)) u_stat_upd (
    .cur (stat_updates),
    .inc (upd_en),
    .dec (1'b0),
    .nxt (upd_nxt)
  );

  sat_counter #(.W(STAT_W)) u_stat_mis (
    .cur (stat_mispredicts),
    .inc (upd_en && upd_mispredict),
    .dec (1'b0),
    .nxt (mis_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++)
        bt_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_updates     <= upd_nxt;
      stat_mispredicts <= mis_nxt;
      // A flush outranks training: only valid bits change, no allocation.
      if (clear) begin
        for (int i = 0; i < ENTRIES; i++)
          bt_q[i].valid <= 1'b0;
      end else if (upd_en) begin
        if (u_hit) begin
          bt_q[u_idx].cnt <= cnt_nxt;
          if (upd_taken)
            bt_q[u_idx].target <= upd_target[WORD_W-1:2];
        end else if (upd_taken) begin
          bt_q[u_idx] <= '{valid: 1'b1, tag: u_tag,
                           target: upd_target[WORD_W-1:2], cnt: CNT_WT};
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, STAT_W=2 saturation run,
// reset-over-training sequence, and randomized traffic against an array model.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] lookup_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_en, upd_taken, upd_mispredict, clear;
  logic [31:0] upd_pc, upd_target;
  logic [15:0] stat_updates, stat_mispredicts;

  logic        s_en, s_mis;
  logic        s_hit, s_taken;
  logic [31:0] s_target;
  logic [1:0]  s_upd, s_misc;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  branch_predictor dut (
    .CLK(CLK), .RST(RST), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict), .clear(clear),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.STAT_W(2)) dut_s (
    .CLK(CLK), .RST(RST), .lookup_pc(lookup_pc),
    .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
    .upd_en(s_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(s_mis), .clear(clear),
    .stat_updates(s_upd), .stat_mispredicts(s_misc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: 16 entries, index = word address mod 16, tag = pc / 64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_cnt   [16];
  int unsigned m_upd, m_mis;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_upd = 0; m_mis = 0;
  endfunction

  function automatic void model_step();
    int unsigned i, t;
    i = (upd_pc / 4) % 16;
    t = upd_pc / 64;
    if (upd_en) begin
      if (m_upd < 65535) m_upd++;
      if (upd_mispredict && m_mis < 65535) m_mis++;
    end
    if (clear) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end else if (upd_en) begin
      if (m_valid[i] && m_tag[i] == t) begin
        m_cnt[i] = upd_taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                             : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        if (upd_taken) m_tgt[i] = upd_target & 32'hFFFF_FFFC;
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = upd_target & 32'hFFFF_FFFC; m_cnt[i] = 2;
      end
    end
  endfunction

  task automatic model_check(input string tag);
    int unsigned i;
    bit          h, tk;
    int unsigned tg;
    i  = (lookup_pc / 4) % 16;
    h  = m_valid[i] && (m_tag[i] == lookup_pc / 64);
    tk = h && (m_cnt[i] >= 2);
    tg = tk ? m_tgt[i] : lookup_pc + 4;
    chk({tag, "_hit"},    32'(pred_hit),    32'(h));
    chk({tag, "_taken"},  32'(pred_taken),  32'(tk));
    chk({tag, "_target"}, pred_target,      tg);
    chk({tag, "_stupd"},  32'(stat_updates), m_upd);
    chk({tag, "_stmis"},  32'(stat_mispredicts), m_mis);
  endtask

  task automatic drive(input bit en, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tgt, input bit mis, input bit clr,
                       input logic [31:0] lk);
    upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_mispredict = mis; clear = clr; lookup_pc = lk;
  endtask

  typedef struct {
    bit          en;
    logic [31:0] pc;
    bit          tk;
    logic [31:0] tgt;
    bit          clr;
    logic [31:0] lk;
    bit          eh;
    bit          et;
    logic [31:0] etg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit en, input logic [31:0] pc, input bit tk,
                              input logic [31:0] tgt, input bit clr, input logic [31:0] lk,
                              input bit eh, input bit et, input logic [31:0] etg);
    vec_t v;
    v = '{en, pc, tk, tgt, clr, lk, eh, et, etg};
    vecs.push_back(v);
  endfunction

  initial begin
    // Each row: inputs for one cycle; expectations describe the lookup seen
    // during that cycle (pre-update state).
    add(0, 32'h40,  0, 32'h0,   0, 32'h40,  0, 0, 32'h44);
    add(1, 32'h40,  1, 32'h100, 0, 32'h40,  0, 0, 32'h44);
    add(0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 1, 32'h100);
    add(1, 32'h40,  0, 32'h0,   0, 32'h40,  1, 1, 32'h100);
    add(1, 32'h40,  0, 32'h0,   0, 32'h40,  1, 0, 32'h44);
    add(1, 32'h40,  0, 32'h0,   0, 32'h40,  1, 0, 32'h44);
    add(1, 32'h40,  0, 32'h0,   0, 32'h40,  1, 0, 32'h44);
    add(1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 0, 32'h44);
    add(1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 0, 32'h44);
    add(1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 1, 32'h100);
    add(1, 32'h40,  1, 32'h100, 0, 32'h40,  1, 1, 32'h100);
    add(1, 32'h40,  0, 32'h0,   0, 32'h40,  1, 1, 32'h100);
    add(1, 32'h40,  0, 32'h0,   0, 32'h40,  1, 1, 32'h100);
    add(0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 0, 32'h44);
    add(1, 32'h80,  1, 32'h200, 0, 32'h80,  0, 0, 32'h84);
    add(0, 32'h0,   0, 32'h0,   0, 32'h40,  0, 0, 32'h44);
    add(0, 32'h0,   0, 32'h0,   0, 32'h80,  1, 1, 32'h200);
    add(1, 32'h40,  1, 32'h104, 0, 32'h40,  0, 0, 32'h44);
    add(1, 32'hC0,  1, 32'h300, 1, 32'h40,  1, 1, 32'h104);
    add(0, 32'h0,   0, 32'h0,   0, 32'h40,  0, 0, 32'h44);
    add(0, 32'h0,   0, 32'h0,   0, 32'hC0,  0, 0, 32'hC4);
    add(1, 32'h40,  1, 32'h108, 0, 32'h40,  0, 0, 32'h44);
    add(1, 32'h40,  1, 32'h10F, 0, 32'h40,  1, 1, 32'h108);
    add(1, 32'h40,  0, 32'h500, 0, 32'h40,  1, 1, 32'h10C);
    add(0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 1, 32'h10C);
    add(1, 32'h140, 0, 32'h0,   0, 32'h40,  1, 1, 32'h10C);
    add(0, 32'h0,   0, 32'h0,   0, 32'h140, 0, 0, 32'h144);
    add(0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 1, 32'h10C);
    add(0, 32'h0,   0, 32'h0,   0, 32'hFFFF_FFFC, 0, 0, 32'h0);

    RST = 1'b1; s_en = 1'b0; s_mis = 1'b0;
    drive(1, 32'h40, 1, 32'h100, 1, 1, 32'h40);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    model_reset();

    @(negedge CLK);
    chk("rst_hit",    32'(pred_hit), 32'd0);
    chk("rst_taken",  32'(pred_taken), 32'd0);
    chk("rst_target", pred_target, 32'h44);
    chk("rst_stupd",  32'(stat_updates), 32'd0);
    chk("rst_stmis",  32'(stat_mispredicts), 32'd0);
    chk("rst_s_mis",  32'(s_misc), 32'd0);
    @(posedge CLK); #1;

    foreach (vecs[r]) begin
      drive(vecs[r].en, vecs[r].pc, vecs[r].tk, vecs[r].tgt,
            vecs[r].en && !vecs[r].tk, vecs[r].clr, vecs[r].lk);
      @(negedge CLK);
      chk($sformatf("vec%0d_hit", r),    32'(pred_hit),   32'(vecs[r].eh));
      chk($sformatf("vec%0d_taken", r),  32'(pred_taken), 32'(vecs[r].et));
      chk($sformatf("vec%0d_target", r), pred_target,     vecs[r].etg);
      chk($sformatf("vec%0d_stupd", r),  32'(stat_updates), m_upd);
      model_step();
      @(posedge CLK); #1;
    end

    // 2-bit statistics saturate at 3.
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    s_en = 1'b1; s_mis = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("sat_mis%0d", k), 32'(s_misc), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("sat_upd%0d", k), 32'(s_upd),  (k < 3) ? 32'(k) : 32'd3);
    end
    s_en = 1'b0; s_mis = 1'b0;

    // Randomized traffic over 4 tags x 16 indices so hits and aliasing are common.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 32'($urandom_range(0, 63)) << 2,
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 24) == 0, 32'($urandom_range(0, 63)) << 2);
      @(negedge CLK);
      model_check($sformatf("rnd%0d", c));
      model_step();
      @(posedge CLK); #1;
    end

    // Reset in the same cycle as a clear and a training update discards everything.
    drive(1, 32'h40, 1, 32'h100, 1, 0, 32'h40);
    @(negedge CLK); model_step(); @(posedge CLK); #1;
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    @(negedge CLK);
    chk("pre_rst_hit", 32'(pred_hit), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    drive(1, 32'h40, 1, 32'h100, 1, 1, 32'h40);
    @(posedge CLK); #1;
    RST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    model_reset();
    @(negedge CLK);
    chk("mid_rst_hit",    32'(pred_hit), 32'd0);
    chk("mid_rst_target", pred_target, 32'h44);
    chk("mid_rst_stupd",  32'(stat_updates), 32'd0);
    chk("mid_rst_s_upd",  32'(s_upd), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
